// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared D-cache types, geometry constants, refill FSM state
//               encoding and block word access helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int DCACHE_BLOCK_SIZE = 512;                          // bits per line
    localparam int DCACHE_SETS       = 64;
    localparam int BLOCK_OFFSET_BITS = $clog2(DCACHE_BLOCK_SIZE / 32); // word-select bits
    localparam int SET_INDEX_BITS    = $clog2(DCACHE_SETS);
    localparam int NUM_TAG_BITS      = 32 - BLOCK_OFFSET_BITS - 2 - SET_INDEX_BITS;

    typedef logic [DCACHE_BLOCK_SIZE-1:0] cache_data_block;

    typedef struct packed {
        logic                    valid;
        logic                    dirty;
        logic [NUM_TAG_BITS-1:0] tag;
    } cache_metadata_block;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_VICTIM    = 3'd2,
        ST_WB_REQ    = 3'd3,
        ST_FILL_REQ  = 3'd4,
        ST_FILL_WAIT = 3'd5,
        ST_WRITE     = 3'd6
    } refill_state_e;

    // Return 32-bit word 'off' of a cache block.
    function automatic logic [31:0] word_extract(input cache_data_block blk,
                                                 input logic [BLOCK_OFFSET_BITS-1:0] off);
        return blk[32*off +: 32];
    endfunction

    // Return a copy of 'blk' with word 'off' replaced by 'w'.
    function automatic cache_data_block word_insert(input cache_data_block blk,
                                                    input logic [BLOCK_OFFSET_BITS-1:0] off,
                                                    input logic [31:0] w);
        cache_data_block r;
        r = blk;
        r[32*off +: 32] = w;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_refill_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dcache_refill_sequencer
// Description : Repairs one L1 D-cache miss at a time: victim lookup,
//               optional dirty writeback, fill read, store-merged cache
//               write and load-result commit to the ROB.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_refill_sequencer
    import dcache_pkg::*;
#(
    parameter int ROB_ENTRIES      = 32,
    parameter int CACHE_BLOCK_SIZE = DCACHE_BLOCK_SIZE,
    localparam int RIDX            = $clog2(ROB_ENTRIES)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        mshr_req_vld_i,
    input  logic [31:0]                 mshr_req_addr_i,
    input  logic [31:0]                 mshr_req_data_i,
    input  logic [RIDX-1:0]             mshr_req_rob_idx_i,
    input  logic                        mshr_req_is_store_i,
    output logic                        mshr_ack_o,
    output logic                        mshr_complete_o,
    output logic                        victim_rd_en_o,
    output logic [31:0]                 victim_rd_addr_o,
    input  logic                        victim_valid_i,
    input  logic                        victim_dirty_i,
    input  logic [31:0]                 victim_addr_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] victim_data_i,
    output logic                        mem_req_vld_o,
    input  logic                        mem_req_rdy_i,
    output logic                        mem_req_we_o,
    output logic [31:0]                 mem_req_addr_o,
    output logic [CACHE_BLOCK_SIZE-1:0] mem_req_data_o,
    input  logic                        mem_resp_vld_i,
    input  logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_i,
    output logic                        cache_wr_en_o,
    output logic [31:0]                 cache_wr_addr_o,
    output logic [CACHE_BLOCK_SIZE-1:0] cache_wr_data_o,
    output logic                        cache_wr_dirty_o,
    output logic                        cmt_ld_vld_o,
    output logic [31:0]                 cmt_ld_data_o,
    output logic [RIDX-1:0]             cmt_rob_idx_o,
    output logic                        busy_o
);

    localparam logic [31:0] C_ALIGN_MASK = ~(32'(CACHE_BLOCK_SIZE / 8) - 32'd1);

    refill_state_e                 state_q, state_d;
    logic [31:0]                   addr_q, addr_d;
    logic [31:0]                   data_q, data_d;
    logic [RIDX-1:0]               rob_q, rob_d;
    logic                          is_store_q, is_store_d;
    logic                          killed_q, killed_d;
    logic [31:0]                   vaddr_q, vaddr_d;
    cache_data_block               blk_q, blk_d;   // victim data, later the fill block

    logic [BLOCK_OFFSET_BITS-1:0]  w_off;
    logic                          w_killed;

    assign w_off    = addr_q[BLOCK_OFFSET_BITS+1:2];
    // A flush landing in the WRITE cycle itself still suppresses the effect.
    assign w_killed = killed_q | flush_i;

    // State and capture registers; reset abandons any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rob_q      <= '0;
            is_store_q <= 1'b0;
            killed_q   <= 1'b0;
            vaddr_q    <= '0;
            blk_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rob_q      <= rob_d;
            is_store_q <= is_store_d;
            killed_q   <= killed_d;
            vaddr_q    <= vaddr_d;
            blk_q      <= blk_d;
        end
    end

    // Next-state, capture and output decode; outputs idle at zero.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        rob_d            = rob_q;
        is_store_d       = is_store_q;
        killed_d         = killed_q | flush_i;
        vaddr_d          = vaddr_q;
        blk_d            = blk_q;

        mshr_ack_o       = 1'b0;
        mshr_complete_o  = 1'b0;
        victim_rd_en_o   = 1'b0;
        victim_rd_addr_o = '0;
        mem_req_vld_o    = 1'b0;
        mem_req_we_o     = 1'b0;
        mem_req_addr_o   = '0;
        mem_req_data_o   = '0;
        cache_wr_en_o    = 1'b0;
        cache_wr_addr_o  = '0;
        cache_wr_data_o  = '0;
        cache_wr_dirty_o = 1'b0;
        cmt_ld_vld_o     = 1'b0;
        cmt_ld_data_o    = '0;
        cmt_rob_idx_o    = '0;
        busy_o           = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                killed_d = 1'b0;
                if (mshr_req_vld_i && !rst_i) begin
                    mshr_ack_o = 1'b1;
                    addr_d     = mshr_req_addr_i;
                    data_d     = mshr_req_data_i;
                    rob_d      = mshr_req_rob_idx_i;
                    is_store_d = mshr_req_is_store_i;
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                victim_rd_en_o   = 1'b1;
                victim_rd_addr_o = addr_q & C_ALIGN_MASK;
                state_d          = ST_VICTIM;
            end
            ST_VICTIM: begin
                if (victim_valid_i && victim_dirty_i) begin
                    vaddr_d = victim_addr_i & C_ALIGN_MASK;
                    blk_d   = victim_data_i;
                    state_d = ST_WB_REQ;
                end else begin
                    state_d = ST_FILL_REQ;
                end
            end
            ST_WB_REQ: begin
                mem_req_vld_o  = 1'b1;
                mem_req_we_o   = 1'b1;
                mem_req_addr_o = vaddr_q;
                mem_req_data_o = blk_q;
                if (mem_req_rdy_i) state_d = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                mem_req_vld_o  = 1'b1;
                mem_req_addr_o = addr_q & C_ALIGN_MASK;
                if (mem_req_rdy_i) state_d = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (mem_resp_vld_i) begin
                    blk_d   = mem_resp_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cache_wr_en_o   = 1'b1;
                mshr_complete_o = 1'b1;
                cache_wr_addr_o = addr_q & C_ALIGN_MASK;
                if (is_store_q && !w_killed) begin
                    cache_wr_data_o  = word_insert(blk_q, w_off, data_q);
                    cache_wr_dirty_o = 1'b1;
                end else begin
                    cache_wr_data_o  = blk_q;
                end
                if (!is_store_q && !w_killed) begin
                    cmt_ld_vld_o  = 1'b1;
                    cmt_ld_data_o = word_extract(blk_q, w_off);
                    cmt_rob_idx_o = rob_q;
                end
                killed_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_refill_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_refill_sequencer
// Description : Directed, table-driven bench for dcache_refill_sequencer
//               with a small memory/victim responder and hand-written
//               reset and back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_refill_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         req_vld = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_data = '0;
    logic [4:0]   req_rob = '0;
    logic         req_store = 1'b0;
    logic         mshr_ack, mshr_complete;
    logic         vrd_en;
    logic [31:0]  vrd_addr;
    logic         v_valid = 1'b0, v_dirty = 1'b0;
    logic [31:0]  v_addr = '0;
    logic [511:0] v_data = '0;
    logic         mreq_vld, mreq_we;
    logic         mreq_rdy = 1'b0;
    logic [31:0]  mreq_addr;
    logic [511:0] mreq_data;
    logic         mresp_vld = 1'b0;
    logic [511:0] mresp_data = '0;
    logic         cwr_en, cwr_dirty;
    logic [31:0]  cwr_addr;
    logic [511:0] cwr_data;
    logic         cmt_vld;
    logic [31:0]  cmt_data;
    logic [4:0]   cmt_rob;
    logic         busy;

    dcache_refill_sequencer #(.ROB_ENTRIES(32), .CACHE_BLOCK_SIZE(512)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .mshr_req_vld_i(req_vld), .mshr_req_addr_i(req_addr),
        .mshr_req_data_i(req_data), .mshr_req_rob_idx_i(req_rob),
        .mshr_req_is_store_i(req_store),
        .mshr_ack_o(mshr_ack), .mshr_complete_o(mshr_complete),
        .victim_rd_en_o(vrd_en), .victim_rd_addr_o(vrd_addr),
        .victim_valid_i(v_valid), .victim_dirty_i(v_dirty),
        .victim_addr_i(v_addr), .victim_data_i(v_data),
        .mem_req_vld_o(mreq_vld), .mem_req_rdy_i(mreq_rdy),
        .mem_req_we_o(mreq_we), .mem_req_addr_o(mreq_addr),
        .mem_req_data_o(mreq_data),
        .mem_resp_vld_i(mresp_vld), .mem_resp_data_i(mresp_data),
        .cache_wr_en_o(cwr_en), .cache_wr_addr_o(cwr_addr),
        .cache_wr_data_o(cwr_data), .cache_wr_dirty_o(cwr_dirty),
        .cmt_ld_vld_o(cmt_vld), .cmt_ld_data_o(cmt_data),
        .cmt_rob_idx_o(cmt_rob), .busy_o(busy)
    );

    always #5 clk = ~clk;

    wire any_out = mshr_ack | mshr_complete | vrd_en | (|vrd_addr) | mreq_vld | mreq_we |
                   (|mreq_addr) | (|mreq_data) | cwr_en | (|cwr_addr) | (|cwr_data) |
                   cwr_dirty | cmt_vld | (|cmt_data) | (|cmt_rob) | busy;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        is_store;
        logic [4:0]  rob;
        logic        vvalid;
        logic        vdirty;
        logic [31:0] vaddr;
        int          wb_stall;
        int          fill_stall;
        int          flush_cyc;
        int          exp_lat;
        int          exp_wb;
        logic        exp_merge;
        logic        exp_dirty;
        logic        exp_cmt;
        int          exp_off;
    } vec_t;

    vec_t vecs[8];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] make_fill(input int seed);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = {8'hF0, 8'(seed), 16'(i * 3 + 1)};
        return b;
    endfunction

    function automatic logic [511:0] make_victim(input int seed);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = {8'hA5, 8'(seed), 16'(i)};
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one repair from request to WRITE, acting as MSHR, victim array and memory.
    task automatic run_vec(input vec_t v, input int idx, input bit hold_vld);
        logic [511:0] fill, vdat, exp_blk;
        logic [511:0] wr_data = '0;
        logic [31:0]  c_data = '0;
        logic [4:0]   c_rob = '0;
        logic         wr_dirty = 1'b0, c_vld = 1'b0, cmpl = 1'b0;
        bit           resp_pend = 0, wb_bad = 0, fill_bad = 0, order_bad = 0, rd_bad = 0;
        int           ack_cyc = -1, wr_cyc = -1, extra_ack = 0, rd_cnt = 0;
        int           wb_seen = 0, fill_seen = 0, wb_acc = 0, fill_acc = 0, stray = 0;
        string        tag;

        tag       = $sformatf("v%0d", idx);
        fill      = make_fill(idx);
        vdat      = make_victim(idx);
        req_vld   = 1'b1;
        req_addr  = v.addr;
        req_data  = v.sdata;
        req_rob   = v.rob;
        req_store = v.is_store;
        v_valid   = v.vvalid;
        v_dirty   = v.vdirty;
        v_addr    = v.vaddr;
        v_data    = vdat;
        for (int cyc = 0; cyc < 200 && wr_cyc < 0; cyc++) begin
            flush      = (cyc == v.flush_cyc);
            mresp_vld  = resp_pend;
            mresp_data = resp_pend ? fill : '0;
            resp_pend  = 0;
            mreq_rdy   = 1'b0;
            #1;
            if (mshr_ack) begin
                if (ack_cyc < 0) ack_cyc = cyc;
                else extra_ack++;
            end
            if (vrd_en) begin
                rd_cnt++;
                if (vrd_addr !== (v.addr & ~32'h3F)) rd_bad = 1;
            end
            if (mreq_vld && mreq_we) begin
                if (fill_seen > 0) order_bad = 1;
                if (mreq_addr !== (v.vaddr & ~32'h3F) || mreq_data !== vdat) wb_bad = 1;
                mreq_rdy = (wb_seen >= v.wb_stall);
                wb_seen++;
                if (mreq_rdy) wb_acc++;
            end else if (mreq_vld) begin
                if (mreq_addr !== (v.addr & ~32'h3F)) fill_bad = 1;
                mreq_rdy = (fill_seen >= v.fill_stall);
                fill_seen++;
                if (mreq_rdy) begin
                    fill_acc++;
                    resp_pend = 1;
                end
            end
            if (cwr_en) begin
                wr_cyc   = cyc;
                wr_data  = cwr_data;
                wr_dirty = cwr_dirty;
                cmpl     = mshr_complete;
                c_vld    = cmt_vld;
                c_data   = cmt_data;
                c_rob    = cmt_rob;
                if (cwr_addr !== (v.addr & ~32'h3F)) stray++;
            end else if (mshr_complete || cmt_vld) begin
                stray++;
            end
            step();
            if (ack_cyc >= 0 && !hold_vld) req_vld = 1'b0;
        end
        flush     = 1'b0;
        mreq_rdy  = 1'b0;
        mresp_vld = 1'b0;

        exp_blk = fill;
        if (v.exp_merge) exp_blk[32*v.exp_off +: 32] = v.sdata;
        check({tag, "_ack_cycle"},   512'(ack_cyc), 512'(0));
        check({tag, "_latency"},     512'(wr_cyc - ack_cyc), 512'(v.exp_lat));
        check({tag, "_extra_ack"},   512'(extra_ack), 512'(0));
        check({tag, "_lookup"},      512'({rd_bad, 8'(rd_cnt)}), 512'({1'b0, 8'd1}));
        check({tag, "_wb_accepts"},  512'(wb_acc), 512'(v.exp_wb));
        check({tag, "_wb_cycles"},   512'(wb_seen), 512'(v.exp_wb * (v.wb_stall + 1)));
        check({tag, "_wb_stable"},   512'({wb_bad, order_bad}), 512'(0));
        check({tag, "_fill_accept"}, 512'(fill_acc), 512'(1));
        check({tag, "_fill_cycles"}, 512'({fill_bad, 8'(fill_seen)}), 512'({1'b0, 8'(v.fill_stall + 1)}));
        check({tag, "_wr_data"},     wr_data, exp_blk);
        check({tag, "_wr_dirty"},    512'(wr_dirty), 512'(v.exp_dirty));
        check({tag, "_complete"},    512'({cmpl, 8'(stray)}), 512'({1'b1, 8'd0}));
        check({tag, "_cmt_vld"},     512'(c_vld), 512'(v.exp_cmt));
        check({tag, "_cmt_data"},    512'(c_data), 512'(v.exp_cmt ? fill[32*v.exp_off +: 32] : 32'h0));
        check({tag, "_cmt_rob"},     512'(c_rob), 512'(v.exp_cmt ? v.rob : 5'd0));
    endtask

    initial begin
        //          addr          sdata         st   rob    vv    vd    vaddr        wbs fs  fl  lat wb mrg  dty  cmt  off
        vecs[0] = '{32'h0000_1044, 32'h0,        1'b0, 5'd5,  1'b1, 1'b0, 32'h0000_3040, 0, 0, -1, 5,  0, 1'b0, 1'b0, 1'b1, 1};
        vecs[1] = '{32'h0000_1084, 32'h0,        1'b0, 5'd6,  1'b1, 1'b1, 32'h0000_2040, 0, 0, -1, 6,  1, 1'b0, 1'b0, 1'b1, 1};
        vecs[2] = '{32'h0000_1048, 32'hDEADBEEF, 1'b1, 5'd7,  1'b1, 1'b0, 32'h0000_3000, 0, 0, -1, 5,  0, 1'b1, 1'b1, 1'b0, 2};
        vecs[3] = '{32'h0000_50FC, 32'h12345678, 1'b1, 5'd8,  1'b1, 1'b1, 32'h0000_2040, 7, 7, -1, 20, 1, 1'b1, 1'b1, 1'b0, 15};
        vecs[4] = '{32'h0000_1044, 32'h0,        1'b0, 5'd9,  1'b1, 1'b0, 32'h0000_3040, 0, 0, 4,  5,  0, 1'b0, 1'b0, 1'b0, 1};
        vecs[5] = '{32'h0000_1048, 32'hCAFEF00D, 1'b1, 5'd10, 1'b1, 1'b0, 32'h0000_0000, 0, 0, 4,  5,  0, 1'b0, 1'b0, 1'b0, 2};
        vecs[6] = '{32'h0000_7000, 32'h0,        1'b0, 5'd11, 1'b1, 1'b0, 32'h0000_0000, 0, 0, 0,  5,  0, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{32'h0000_123C, 32'h0,        1'b0, 5'd12, 1'b0, 1'b1, 32'h0000_4440, 0, 0, -1, 5,  0, 1'b0, 1'b0, 1'b1, 15};

        // Reset state, with a pending request that must not be acked.
        rst     = 1'b1;
        req_vld = 1'b1;
        step();
        step();
        check("reset_outputs", 512'(any_out), 512'(0));
        req_vld = 1'b0;
        rst     = 1'b0;
        step();
        check("idle_outputs", 512'(any_out), 512'(0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i, 1'b0);

        // Back-to-back: request held through WRITE; ack only in the following IDLE cycle.
        run_vec(vecs[0], 0, 1'b1);
        #1;
        check("b2b_ack_after_write", 512'(mshr_ack), 512'(1));
        step();
        req_vld  = 1'b0;
        mreq_rdy = 1'b1;
        step();                                // VICTIM
        step();                                // FILL_REQ, accepted
        step();                                // FILL_WAIT
        mreq_rdy = 1'b0;
        check("busy_in_fill_wait", 512'(busy), 512'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_abort_outputs", 512'(any_out), 512'(0));
        // A stale response after the abort must be ignored.
        mresp_vld  = 1'b1;
        mresp_data = make_fill(99);
        step();
        mresp_vld = 1'b0;
        check("stale_resp_ignored", 512'(any_out), 512'(0));

        run_vec(vecs[0], 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
